// File: rtl/overcooked_pkg.sv
`default_nettype none
// ============================================================================
// Module   : overcooked_pkg
// Brief    : Shared kitchen geometry, game states and the walkable floor map.
// Revision : 1.0 - initial release
// ============================================================================
package overcooked_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    localparam logic [2:0] GS_START = 3'd0;
    localparam logic [2:0] GS_PLAY  = 3'd1;

    localparam int TILE      = 32;
    localparam int GRID_COLS = 13;
    localparam int GRID_ROWS = 8;
    localparam int GRID_X0   = 96;
    localparam int GRID_Y0   = 48;

    // Row 7 is the MSB slice; bit index within a row is the column.
    localparam logic [GRID_ROWS-1:0][GRID_COLS-1:0] WALKABLE = {
        13'h0000,
        13'h0FFE,
        13'h0FFE,
        13'h0FFE,
        13'h0E0E,
        13'h0FFE,
        13'h0FFE,
        13'h0000
    };

    function automatic logic is_walkable(input logic [2:0] row, input logic [3:0] col);
        is_walkable = 1'b0;
        if (col < 4'(GRID_COLS)) begin
            is_walkable = WALKABLE[row][col];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/player_move_tile_check.sv
`default_nettype none
// ============================================================================
// Module   : player_move_tile_check
// Brief    : Combinational legality check of a 32x32 box at (pos_x, pos_y).
// Revision : 1.0 - initial release
// ============================================================================
module player_move_tile_check
    import overcooked_pkg::*;
(
    input  logic signed [9:0] pos_x,
    input  logic signed [9:0] pos_y,
    output logic              legal
);

    logic [3:0] corner_ok;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_corner
            localparam logic signed [10:0] C_OFF_X = (k % 2 == 1) ? 11'sd31 : 11'sd0;
            localparam logic signed [10:0] C_OFF_Y = (k / 2 == 1) ? 11'sd31 : 11'sd0;

            logic signed [10:0] rel_x;
            logic signed [10:0] rel_y;
            logic               in_grid;

            // One extra bit so corner offsets near the right/bottom edges cannot wrap.
            assign rel_x   = {pos_x[9], pos_x} + C_OFF_X - 11'(GRID_X0);
            assign rel_y   = {pos_y[9], pos_y} + C_OFF_Y - 11'(GRID_Y0);
            assign in_grid = (rel_x >= 11'sd0) && (rel_x <= 11'(GRID_COLS * TILE - 1)) &&
                             (rel_y >= 11'sd0) && (rel_y <= 11'(GRID_ROWS * TILE - 1));

            assign corner_ok[k] = in_grid && is_walkable(rel_y[7:5], rel_x[8:5]);
        end
    endgenerate

    assign legal = &corner_ok;

endmodule
`default_nettype wire

// File: rtl/player_move.sv
`default_nettype none
// ============================================================================
// Module   : player_move
// Brief    : Per-frame player position/facing update clipped to the floor map.
// Revision : 1.0 - initial release
// ============================================================================
module player_move
    import overcooked_pkg::*;
#(
    parameter int START_X = 300,
    parameter int START_Y = 208
) (
    input  logic       vsync,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic [2:0] game_state,
    output logic [8:0] player_loc_x,
    output logic [8:0] player_loc_y,
    output logic [1:0] player_direction,
    output logic       moving,
    output logic       blocked,
    output logic [1:0] walk_frame
);

    logic [8:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    dir_e       dir_q, dir_d;
    logic       moving_q, moving_d;
    logic       blocked_q, blocked_d;
    logic [1:0] walk_frame_q, walk_frame_d;
    logic [3:0] hold_q, hold_d;
    logic [2:0] step_q, step_d;

    logic              req_valid;
    dir_e              req_dir;
    logic              fast;
    logic signed [9:0] step_s;
    logic signed [9:0] pos_x_s, pos_y_s;
    logic signed [9:0] full_x, full_y, one_x, one_y;
    logic              full_ok, one_ok;

    always_comb begin
        req_valid = up | right | down | left;
        req_dir   = DIR_UP;
        if (up) begin
            req_dir = DIR_UP;
        end else if (right) begin
            req_dir = DIR_RIGHT;
        end else if (down) begin
            req_dir = DIR_DOWN;
        end else if (left) begin
            req_dir = DIR_LEFT;
        end
    end

    assign fast    = (hold_q >= 4'd8);
    assign step_s  = fast ? 10'sd2 : 10'sd1;
    assign pos_x_s = $signed({1'b0, x_q});
    assign pos_y_s = $signed({1'b0, y_q});

    // Full-step and 1-pixel candidates are evaluated side by side.
    always_comb begin
        full_x = pos_x_s;
        full_y = pos_y_s;
        one_x  = pos_x_s;
        one_y  = pos_y_s;
        case (dir_q)
            DIR_UP: begin
                full_y = pos_y_s - step_s;
                one_y  = pos_y_s - 10'sd1;
            end
            DIR_RIGHT: begin
                full_x = pos_x_s + step_s;
                one_x  = pos_x_s + 10'sd1;
            end
            DIR_DOWN: begin
                full_y = pos_y_s + step_s;
                one_y  = pos_y_s + 10'sd1;
            end
            default: begin
                full_x = pos_x_s - step_s;
                one_x  = pos_x_s - 10'sd1;
            end
        endcase
    end

    player_move_tile_check u_check_full (
        .pos_x (full_x),
        .pos_y (full_y),
        .legal (full_ok)
    );

    player_move_tile_check u_check_one (
        .pos_x (one_x),
        .pos_y (one_y),
        .legal (one_ok)
    );

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        dir_d        = dir_q;
        moving_d     = 1'b0;
        blocked_d    = 1'b0;
        walk_frame_d = walk_frame_q;
        hold_d       = hold_q;
        step_d       = step_q;

        case (game_state)
            GS_START: begin
                x_d          = 9'(START_X);
                y_d          = 9'(START_Y);
                dir_d        = DIR_UP;
                walk_frame_d = 2'd0;
                hold_d       = 4'd0;
                step_d       = 3'd0;
            end
            GS_PLAY: begin
                if (!req_valid) begin
                    hold_d       = 4'd0;
                    step_d       = 3'd0;
                    walk_frame_d = 2'd0;
                end else if (req_dir != dir_q) begin
                    dir_d  = req_dir;
                    hold_d = 4'd0;
                end else begin
                    hold_d = (hold_q == 4'd15) ? 4'd15 : hold_q + 4'd1;
                    if (full_ok || (fast && one_ok)) begin
                        x_d      = full_ok ? full_x[8:0] : one_x[8:0];
                        y_d      = full_ok ? full_y[8:0] : one_y[8:0];
                        moving_d = 1'b1;
                        step_d   = step_q + 3'd1;
                        if (step_q == 3'd7) begin
                            walk_frame_d = walk_frame_q + 2'd1;
                        end
                    end else begin
                        blocked_d    = 1'b1;
                        step_d       = 3'd0;
                        walk_frame_d = 2'd0;
                    end
                end
            end
            default: begin
                hold_d       = 4'd0;
                step_d       = 3'd0;
                walk_frame_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge vsync or posedge reset) begin
        if (reset) begin
            x_q          <= 9'(START_X);
            y_q          <= 9'(START_Y);
            dir_q        <= DIR_UP;
            moving_q     <= 1'b0;
            blocked_q    <= 1'b0;
            walk_frame_q <= 2'd0;
            hold_q       <= 4'd0;
            step_q       <= 3'd0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            dir_q        <= dir_d;
            moving_q     <= moving_d;
            blocked_q    <= blocked_d;
            walk_frame_q <= walk_frame_d;
            hold_q       <= hold_d;
            step_q       <= step_d;
        end
    end

    assign player_loc_x     = x_q;
    assign player_loc_y     = y_q;
    assign player_direction = dir_q;
    assign moving           = moving_q;
    assign blocked          = blocked_q;
    assign walk_frame       = walk_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_player_move.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_move
// Brief    : Directed self-checking bench for player_move.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_move;

    logic       vsync = 1'b0;
    logic       reset = 1'b1;
    logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic [2:0] game_state = 3'd1;
    logic [8:0] player_loc_x, player_loc_y;
    logic [1:0] player_direction, walk_frame;
    logic       moving, blocked;

    int checks   = 0;
    int failures = 0;

    player_move dut (
        .vsync            (vsync),
        .reset            (reset),
        .left             (left),
        .right            (right),
        .up               (up),
        .down             (down),
        .game_state       (game_state),
        .player_loc_x     (player_loc_x),
        .player_loc_y     (player_loc_y),
        .player_direction (player_direction),
        .moving           (moving),
        .blocked          (blocked),
        .walk_frame       (walk_frame)
    );

    always #5 vsync = ~vsync;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic btn(input logic u, input logic r, input logic d, input logic l);
        up = u; right = r; down = d; left = l;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge vsync);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge vsync);
        reset = 1'b1;
        #1;
        @(negedge vsync);
        reset = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_x", 32'(player_loc_x), 300);
        chk("rst_y", 32'(player_loc_y), 208);
        chk("rst_dir", 32'(player_direction), 0);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_blocked", 32'(blocked), 0);
        chk("rst_wf", 32'(walk_frame), 0);
        @(negedge vsync);
        reset = 1'b0;

        // Walk down into the bottom counter
        btn(0, 0, 1, 0);
        frames(1);
        chk("down_turn_dir", 32'(player_direction), 2);
        chk("down_turn_y", 32'(player_loc_y), 208);
        chk("down_turn_moving", 32'(moving), 0);
        frames(8);
        chk("down_slow_y", 32'(player_loc_y), 216);
        chk("down_slow_moving", 32'(moving), 1);
        frames(8);
        chk("down_16_y", 32'(player_loc_y), 232);
        chk("down_16_wf", 32'(walk_frame), 2);
        frames(4);
        chk("down_fast_y", 32'(player_loc_y), 240);
        frames(1);
        chk("down_block_y", 32'(player_loc_y), 240);
        chk("down_block_blocked", 32'(blocked), 1);
        chk("down_block_moving", 32'(moving), 0);
        chk("down_block_wf", 32'(walk_frame), 0);
        btn(0, 0, 0, 0);
        frames(1);
        chk("release_blocked", 32'(blocked), 0);

        // Asynchronous reset lands between edges
        @(negedge vsync);
        reset = 1'b1;
        #1;
        chk("async_rst_y", 32'(player_loc_y), 208);
        chk("async_rst_dir", 32'(player_direction), 0);
        @(negedge vsync);
        reset = 1'b0;

        // Slide to contact against the island (already facing up)
        btn(1, 0, 0, 0);
        frames(3);
        chk("slide_pre_y", 32'(player_loc_y), 205);
        btn(0, 0, 0, 0);
        frames(1);
        btn(1, 0, 0, 0);
        frames(8);
        chk("slide_slow_y", 32'(player_loc_y), 197);
        frames(10);
        chk("slide_fast_y", 32'(player_loc_y), 177);
        frames(1);
        chk("slide_contact_y", 32'(player_loc_y), 176);
        chk("slide_contact_moving", 32'(moving), 1);
        chk("slide_contact_blocked", 32'(blocked), 0);
        frames(1);
        chk("slide_block_y", 32'(player_loc_y), 176);
        chk("slide_block_blocked", 32'(blocked), 1);
        btn(0, 0, 0, 0);

        // Priority and turning
        do_reset();
        btn(1, 0, 0, 1);
        frames(1);
        chk("prio_y", 32'(player_loc_y), 207);
        chk("prio_x", 32'(player_loc_x), 300);
        chk("prio_dir", 32'(player_direction), 0);
        btn(0, 0, 0, 1);
        frames(1);
        chk("turn_left_dir", 32'(player_direction), 3);
        chk("turn_left_x", 32'(player_loc_x), 300);
        chk("turn_left_moving", 32'(moving), 0);
        frames(1);
        chk("walk_left_x", 32'(player_loc_x), 299);
        chk("walk_left_moving", 32'(moving), 1);

        // Game-state gating
        game_state = 3'd2;
        frames(2);
        chk("freeze_x", 32'(player_loc_x), 299);
        chk("freeze_y", 32'(player_loc_y), 207);
        chk("freeze_moving", 32'(moving), 0);
        chk("freeze_dir", 32'(player_direction), 3);
        game_state = 3'd0;
        frames(1);
        chk("start_x", 32'(player_loc_x), 300);
        chk("start_y", 32'(player_loc_y), 208);
        chk("start_dir", 32'(player_direction), 0);
        game_state = 3'd1;
        btn(0, 0, 0, 0);

        // Walk animation: 16 commits then release
        do_reset();
        btn(0, 0, 1, 0);
        frames(8);
        chk("anim_8_wf", 32'(walk_frame), 0);
        frames(1);
        chk("anim_8c_wf", 32'(walk_frame), 1);
        frames(8);
        chk("anim_16_wf", 32'(walk_frame), 2);
        btn(0, 0, 0, 0);
        frames(1);
        chk("anim_release_wf", 32'(walk_frame), 0);
        chk("anim_release_moving", 32'(moving), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
